// File: rtl/button_event_decoder_pkg.sv
// Shared types and default timing constants for the button event decoder
// and the game controller that configures it.
package button_event_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS  = 3'd1,
        ST_LONG   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_SECOND = 3'd4
    } state_t;

    localparam int DEF_LONG_CYCLES = 8;
    localparam int DEF_DOUBLE_GAP  = 6;
    localparam int DEF_CNT_W       = 16;
    localparam int PRESS_CNT_W     = 8;

endpackage

// File: rtl/button_event_decoder_edge_detect.sv
// Rise/fall detector on a level already synchronous to clk_i.
// The previous-sample register resets high so a level held through reset is not a rise.
module button_event_decoder_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic rise_o,
    output logic fall_o
);

    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level_i;
        end
    end

    assign rise_o = level_i & ~prev_q;
    assign fall_o = ~level_i & prev_q;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button activity into press, long, click and double events.
// One shared counter times either the hold (PRESS) or the release gap (WAIT).
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int LONG_CYCLES = DEF_LONG_CYCLES,
    parameter int DOUBLE_GAP  = DEF_DOUBLE_GAP,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cleanb_i,
    output logic                   held_o,
    output logic                   press_pulse_o,
    output logic                   long_pulse_o,
    output logic                   click_pulse_o,
    output logic                   double_pulse_o,
    output logic [PRESS_CNT_W-1:0] press_count_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(DOUBLE_GAP);

    logic rise;
    logic fall;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   held_q;
    logic                   press_q;
    logic                   long_q;
    logic                   click_q;
    logic                   double_q;
    logic [PRESS_CNT_W-1:0] press_count_q;

    button_event_decoder_edge_detect u_edge (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .level_i (cleanb_i),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            held_q        <= 1'b0;
            press_q       <= 1'b0;
            long_q        <= 1'b0;
            click_q       <= 1'b0;
            double_q      <= 1'b0;
            press_count_q <= '0;
        end else begin
            held_q   <= cleanb_i;
            press_q  <= 1'b0;
            long_q   <= 1'b0;
            click_q  <= 1'b0;
            double_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_q       <= ST_PRESS;
                        press_q       <= 1'b1;
                        cnt_q         <= CNT_ONE;
                        press_count_q <= press_count_q + 8'd1;
                    end
                end
                ST_PRESS: begin
                    if (fall) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= CNT_ONE;
                    end else if (cleanb_i) begin
                        // counter holds at its terminal value instead of wrapping
                        if (cnt_q == LONG_TC) begin
                            state_q <= ST_LONG;
                            long_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_LONG: begin
                    if (fall) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                end
                ST_WAIT: begin
                    // a press on the expiry edge still counts as the second press
                    if (rise) begin
                        state_q       <= ST_SECOND;
                        press_q       <= 1'b1;
                        double_q      <= 1'b1;
                        cnt_q         <= '0;
                        press_count_q <= press_count_q + 8'd1;
                    end else if (!cleanb_i) begin
                        if (cnt_q == GAP_TC) begin
                            state_q <= ST_IDLE;
                            click_q <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_SECOND: begin
                    if (fall) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign held_o         = held_q;
    assign press_pulse_o  = press_q;
    assign long_pulse_o   = long_q;
    assign click_pulse_o  = click_q;
    assign double_pulse_o = double_q;
    assign press_count_o  = press_count_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder: per-cycle vector table plus
// hand sequences for reset behaviour and press counter wrap.
module tb_button_event_decoder;

    logic       clk;
    logic       rst;
    logic       cleanb;
    logic       held;
    logic       press_pulse;
    logic       long_pulse;
    logic       click_pulse;
    logic       double_pulse;
    logic [7:0] press_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit       c;
        bit [3:0] exp;   // {press, long, click, double}
        int       cnt;   // expected press_count after this cycle, -1 = not checked
    } vec_t;

    vec_t vecs[$];

    button_event_decoder dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cleanb_i       (cleanb),
        .held_o         (held),
        .press_pulse_o  (press_pulse),
        .long_pulse_o   (long_pulse),
        .click_pulse_o  (click_pulse),
        .double_pulse_o (double_pulse),
        .press_count_o  (press_count)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && !$onehot0({long_pulse, click_pulse, double_pulse})) begin
            errors++;
            $display("FAIL overlap t=%0t long=%0b click=%0b double=%0b required at most one high",
                     $time, long_pulse, click_pulse, double_pulse);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input bit c);
        @(negedge clk);
        cleanb = c;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit c, input bit p, input bit l, input bit k, input bit d);
        vec_t v;
        v.c   = c;
        v.exp = {p, l, k, d};
        v.cnt = -1;
        vecs.push_back(v);
    endtask

    task automatic lows(input int n);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic highs(input int n);
        for (int i = 0; i < n; i++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cnt_at(input int n);
        vecs[vecs.size()-1].cnt = n;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cleanb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cleanb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pulses", {28'd0, press_pulse, long_pulse, click_pulse, double_pulse}, 32'd0);
        check("reset_held", {31'd0, held}, 32'd0);
        check("reset_count", {24'd0, press_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // vector table, starting from IDLE with count 0
        lows(2);
        // short press then gap expiry: click on the 7th low sample
        add(1, 1, 0, 0, 0); highs(2);
        lows(6); add(0, 0, 0, 1, 0); lows(1); cnt_at(1);
        // 12-cycle hold: long 7 edges after press, no click on release
        add(1, 1, 0, 0, 0); highs(6); add(1, 0, 1, 0, 0); highs(4);
        lows(8); cnt_at(2);
        // double click
        add(1, 1, 0, 0, 0); highs(1); lows(3); add(1, 1, 0, 0, 1); highs(1);
        lows(8); cnt_at(4);
        // second press on the gap expiry edge still forms a double
        add(1, 1, 0, 0, 0); lows(6); add(1, 1, 0, 0, 1);
        lows(8); cnt_at(6);
        // gap fully expires, following press starts fresh
        add(1, 1, 0, 0, 0); lows(6); add(0, 0, 0, 1, 0); add(1, 1, 0, 0, 0);
        lows(6); add(0, 0, 0, 1, 0); lows(1); cnt_at(8);
        // released exactly after long fires
        add(1, 1, 0, 0, 0); highs(6); add(1, 0, 1, 0, 0);
        lows(8); cnt_at(9);
        // third press after a double is a fresh single
        add(1, 1, 0, 0, 0); lows(1); add(1, 1, 0, 0, 1); lows(1); add(1, 1, 0, 0, 0);
        lows(6); add(0, 0, 0, 1, 0); lows(1); cnt_at(12);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].c);
            check($sformatf("vec%0d_pulses", i),
                  {28'd0, press_pulse, long_pulse, click_pulse, double_pulse},
                  {28'd0, vecs[i].exp});
            check($sformatf("vec%0d_held", i), {31'd0, held}, {31'd0, vecs[i].c});
            if (vecs[i].cnt >= 0)
                check($sformatf("vec%0d_count", i), {24'd0, press_count}, 32'(vecs[i].cnt));
        end

        // button held through reset produces nothing until released and pressed again
        @(negedge clk);
        cleanb = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_async_count", {24'd0, press_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            check("held_thru_rst_pulses", {28'd0, press_pulse, long_pulse, click_pulse, double_pulse}, 32'd0);
        end
        check("held_thru_rst_held", {31'd0, held}, 32'd1);
        step(1'b0);
        check("rel_after_rst", {28'd0, press_pulse, long_pulse, click_pulse, double_pulse}, 32'd0);
        step(1'b1);
        check("press_after_rst", {28'd0, press_pulse, long_pulse, click_pulse, double_pulse}, 32'b1000);
        check("press_after_rst_cnt", {24'd0, press_count}, 32'd1);

        // reset asserted while in WAIT clears everything immediately and aborts the click
        step(1'b0);
        step(1'b0);
        #1;
        rst = 1'b1;
        #1;
        check("rst_wait_pulses", {28'd0, press_pulse, long_pulse, click_pulse, double_pulse}, 32'd0);
        check("rst_wait_count", {24'd0, press_count}, 32'd0);
        check("rst_wait_held", {31'd0, held}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            check("post_rst_silent", {28'd0, press_pulse, long_pulse, click_pulse, double_pulse}, 32'd0);
        end

        // press reset mid-pulse: no pulse survives the reset
        step(1'b1);
        check("pre_rst_press", {31'd0, press_pulse}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_kills_press", {31'd0, press_pulse}, 32'd0);
        do_reset();

        // 256 presses wrap the counter; alternate presses pair into doubles
        for (int i = 0; i < 256; i++) begin
            step(1'b1);
            if (i == 254) check("count_255", {24'd0, press_count}, 32'd255);
            if (i == 255) check("last_is_double", {31'd0, double_pulse}, 32'd1);
            step(1'b0);
        end
        check("count_wrap", {24'd0, press_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
